// File: rtl/axi_lite_spi_ctrl_pkg.sv
`default_nettype none
// axi_lite_spi_ctrl_pkg: register map, field positions, response codes and launch-FSM states.
package axi_lite_spi_ctrl_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_TIMING = 32'h04;
  localparam logic [31:0] OFF_TXDATA = 32'h08;
  localparam logic [31:0] OFF_RXDATA = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;

  localparam int CTRL_MODE_LSB  = 0;
  localparam int CTRL_SPEED_LSB = 2;
  localparam int CTRL_WLEN_LSB  = 4;
  localparam int CTRL_START_BIT = 8;
  localparam int CTRL_IE_BIT    = 9;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  // Storable bits only; START is a strobe and never held.
  localparam logic [31:0] CTRL_RW_MASK   = 32'h0000_023F;
  localparam logic [31:0] TIMING_RW_MASK = 32'h00FF_FFFF;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_GAP    = 2'd2,
    ST_ACTIVE = 2'd3
  } launch_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL   = 3'd0,
    SEL_TIMING = 3'd1,
    SEL_TXDATA = 3'd2,
    SEL_RXDATA = 3'd3,
    SEL_STATUS = 3'd4,
    SEL_NONE   = 3'd5
  } reg_sel_e;

  // Exact match, so misaligned addresses decode as unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    case (addr)
      OFF_CTRL:   return SEL_CTRL;
      OFF_TIMING: return SEL_TIMING;
      OFF_TXDATA: return SEL_TXDATA;
      OFF_RXDATA: return SEL_RXDATA;
      OFF_STATUS: return SEL_STATUS;
      default:    return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_spi_ctrl_launch_fsm.sv
`default_nettype none
// spi_launch_fsm: pulses start until the SPI master goes busy, then captures RX on completion.
module spi_launch_fsm
  import axi_lite_spi_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_launch,
  input  logic        i_busy,
  input  logic [31:0] i_miso_data,
  output logic        o_start,
  output logic        o_busy,
  output logic        o_done_set,
  output logic [31:0] o_rx_data
);

  launch_state_e r_state;
  launch_state_e w_state_nxt;
  logic [31:0]   r_rx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_done_set) r_rx_data <= i_miso_data;
    end
  end

  // GAP falls back to ARM so the master sees a fresh rising edge each retry.
  always_comb begin
    w_state_nxt = r_state;
    o_start     = 1'b0;
    o_done_set  = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_launch) w_state_nxt = ST_ARM;
      ST_ARM: begin
        o_start     = 1'b1;
        w_state_nxt = ST_GAP;
      end
      ST_GAP:    w_state_nxt = i_busy ? ST_ACTIVE : ST_ARM;
      ST_ACTIVE: begin
        if (!i_busy) begin
          o_done_set  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: rtl/axi_lite_spi_ctrl.sv
`default_nettype none
// axi_lite_spi_ctrl: AXI4-Lite register bank driving the SPI master's config, data and start.
module axi_lite_spi_ctrl
  import axi_lite_spi_ctrl_pkg::*;
#(
  parameter int         ADDR_W     = 5,
  parameter logic [7:0] IFG_RST    = 8'd4,
  parameter logic [7:0] CS_SCK_RST = 8'd2,
  parameter logic [7:0] SCK_CS_RST = 8'd2
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              start_o,
  input  logic              busy_i,
  output logic [1:0]        spi_mode_o,
  output logic [1:0]        sck_speed_o,
  output logic [1:0]        word_len_o,
  output logic [7:0]        t_IFG_o,
  output logic [7:0]        t_CS_SCK_o,
  output logic [7:0]        t_SCK_CS_o,
  output logic [31:0]       mosi_data_o,
  input  logic [31:0]       miso_data_i,
  output logic              irq_o
);

  localparam logic [31:0] c_TIMING_RST = {8'h00, SCK_CS_RST, CS_SCK_RST, IFG_RST};

  logic              r_aw_full, r_w_full, r_bvalid, r_rvalid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata, r_rdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp, r_rresp;
  logic [31:0]       r_ctrl, r_timing, r_txdata;
  logic              r_done, r_start_err;

  logic        w_fsm_busy, w_done_set, w_launch, w_wr_exec, w_wr_blocked;
  logic        w_start_req, w_st_wr, w_awready, w_wready, w_arready;
  logic [31:0] w_rx_data, w_ctrl_new, w_wmask, w_status, w_rd_val;
  reg_sel_e    w_wsel, w_rsel;

  assign w_awready = ~RST & ~r_aw_full & ~r_bvalid;
  assign w_wready  = ~RST & ~r_w_full & ~r_bvalid;
  assign w_arready = ~RST & ~r_rvalid;

  assign w_wsel       = decode_addr(32'(r_awaddr));
  assign w_rsel       = decode_addr(32'(s_axi_araddr));
  assign w_wr_exec    = r_aw_full & r_w_full & ~r_bvalid;
  assign w_ctrl_new   = merge_strb(r_ctrl, r_wdata, r_wstrb);
  assign w_wmask      = merge_strb('0, r_wdata, r_wstrb);
  // The master samples config live, so config writes are refused mid-transfer.
  assign w_wr_blocked = w_fsm_busy & (w_wsel inside {SEL_CTRL, SEL_TIMING, SEL_TXDATA});
  assign w_start_req  = (w_wsel == SEL_CTRL) & w_ctrl_new[CTRL_START_BIT];
  assign w_launch     = w_wr_exec & w_start_req & ~w_fsm_busy;
  assign w_st_wr      = w_wr_exec & (w_wsel == SEL_STATUS);

  always_ff @(posedge GCLK) begin
    if (RST) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_ctrl    <= '0;
      r_timing  <= c_TIMING_RST;
      r_txdata  <= '0;
    end else begin
      if (s_axi_awvalid && w_awready) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (s_axi_wvalid && w_wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_wr_exec) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wsel == SEL_NONE || w_wr_blocked) ? RESP_SLVERR : RESP_OKAY;
        if (!w_wr_blocked) begin
          case (w_wsel)
            SEL_CTRL:   r_ctrl   <= w_ctrl_new & CTRL_RW_MASK;
            SEL_TIMING: r_timing <= merge_strb(r_timing, r_wdata, r_wstrb) & TIMING_RW_MASK;
            SEL_TXDATA: r_txdata <= merge_strb(r_txdata, r_wdata, r_wstrb);
            default: ;
          endcase
        end
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid  <= 1'b0;
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end
    end
  end

  // Hardware set takes priority over a coincident W1C clear.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      if (w_done_set)
        r_done <= 1'b1;
      else if (w_launch || (w_st_wr && w_wmask[STAT_DONE_BIT]))
        r_done <= 1'b0;
      if (w_wr_exec && w_start_req && w_fsm_busy)
        r_start_err <= 1'b1;
      else if (w_st_wr && w_wmask[STAT_ERR_BIT])
        r_start_err <= 1'b0;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_BUSY_BIT] = w_fsm_busy;
    w_status[STAT_DONE_BIT] = r_done;
    w_status[STAT_ERR_BIT]  = r_start_err;
  end

  always_comb begin
    w_rd_val = '0;
    case (w_rsel)
      SEL_CTRL:   w_rd_val = r_ctrl;
      SEL_TIMING: w_rd_val = r_timing;
      SEL_TXDATA: w_rd_val = r_txdata;
      SEL_RXDATA: w_rd_val = w_rx_data;
      SEL_STATUS: w_rd_val = w_status;
      default:    w_rd_val = '0;
    endcase
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && w_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_val;
      r_rresp  <= (w_rsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  spi_launch_fsm u_launch (
    .clk         (GCLK),
    .rst         (RST),
    .i_launch    (w_launch),
    .i_busy      (busy_i),
    .i_miso_data (miso_data_i),
    .o_start     (start_o),
    .o_busy      (w_fsm_busy),
    .o_done_set  (w_done_set),
    .o_rx_data   (w_rx_data)
  );

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_arready = w_arready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

  assign spi_mode_o  = r_ctrl[CTRL_MODE_LSB +: 2];
  assign sck_speed_o = r_ctrl[CTRL_SPEED_LSB +: 2];
  assign word_len_o  = r_ctrl[CTRL_WLEN_LSB +: 2];
  assign t_IFG_o     = r_timing[7:0];
  assign t_CS_SCK_o  = r_timing[15:8];
  assign t_SCK_CS_o  = r_timing[23:16];
  assign mosi_data_o = r_txdata;
  assign irq_o       = r_done & r_ctrl[CTRL_IE_BIT];

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_spi_ctrl.sv
`default_nettype none
// tb_axi_lite_spi_ctrl: randomized register/transfer scenarios checked against a register-map model.
module tb_axi_lite_spi_ctrl;

  logic        GCLK = 1'b0;
  logic        RST;
  logic [4:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        start_o, busy_i, irq_o;
  logic [1:0]  spi_mode_o, sck_speed_o, word_len_o;
  logic [7:0]  t_IFG_o, t_CS_SCK_o, t_SCK_CS_o;
  logic [31:0] mosi_data_o, miso_data_i;

  axi_lite_spi_ctrl dut (
    .GCLK(GCLK), .RST(RST),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .start_o(start_o), .busy_i(busy_i), .spi_mode_o(spi_mode_o), .sck_speed_o(sck_speed_o),
    .word_len_o(word_len_o), .t_IFG_o(t_IFG_o), .t_CS_SCK_o(t_CS_SCK_o), .t_SCK_CS_o(t_SCK_CS_o),
    .mosi_data_o(mosi_data_o), .miso_data_i(miso_data_i), .irq_o(irq_o)
  );

  always #5 GCLK = ~GCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Register-map model.
  logic [31:0] m_ctrl, m_timing, m_tx, m_rx;
  logic        m_done, m_err;

  function automatic void m_reset();
    m_ctrl = 0; m_timing = 32'h0002_0204; m_tx = 0; m_rx = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic logic [1:0] m_write(input logic [4:0] a, input logic [31:0] d,
                                         input logic [3:0] s, input bit active);
    logic [31:0] bm;
    bm = 0;
    for (int b = 0; b < 4; b++) if (s[b]) bm[8*b +: 8] = 8'hFF;
    case (a)
      5'h00: begin
        if (active) begin
          if (s[1] && d[8]) m_err = 1;
          return 2'b10;
        end
        m_ctrl = ((m_ctrl & ~bm) | (d & bm)) & 32'h0000_023F;
        if (s[1] && d[8]) m_done = 0;
        return 2'b00;
      end
      5'h04: begin
        if (active) return 2'b10;
        m_timing = ((m_timing & ~bm) | (d & bm)) & 32'h00FF_FFFF;
        return 2'b00;
      end
      5'h08: begin
        if (active) return 2'b10;
        m_tx = (m_tx & ~bm) | (d & bm);
        return 2'b00;
      end
      5'h0C: return 2'b00;
      5'h10: begin
        if (s[0] && d[1]) m_done = 0;
        if (s[0] && d[2]) m_err = 0;
        return 2'b00;
      end
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [33:0] m_read(input logic [4:0] a, input bit active);
    case (a)
      5'h00:   return {2'b00, m_ctrl};
      5'h04:   return {2'b00, m_timing};
      5'h08:   return {2'b00, m_tx};
      5'h0C:   return {2'b00, m_rx};
      5'h10:   return {2'b00, 29'd0, m_err, m_done, active};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  // SPI master stand-in: ignores m_skip start pulses, then stays busy for m_len cycles.
  int          m_skip = 0;
  int          m_len  = 10;
  logic [31:0] m_rxw  = 0;

  initial begin
    busy_i = 0; miso_data_i = 0;
    forever begin
      @(negedge GCLK);
      if (start_o && !RST) begin
        if (m_skip > 0) m_skip--;
        else begin
          busy_i = 1; miso_data_i = m_rxw;
          for (int i = 0; i < m_len && !RST; i++) @(negedge GCLK);
          busy_i = 0;
        end
      end
    end
  end

  int start_cnt = 0;
  int start_dbl = 0;
  logic prev_start = 0;
  always @(negedge GCLK) begin
    if (start_o) start_cnt++;
    if (start_o && prev_start) start_dbl++;
    prev_start = start_o;
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n; bit aw_done, w_done, aw_hs, w_hs;
    s_axi_awaddr = a; s_axi_awvalid = 1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge GCLK); #1;
      if (aw_hs) begin s_axi_awvalid = 0; aw_done = 1; end
      if (w_hs)  begin s_axi_wvalid = 0;  w_done = 1;  end
      n++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 1; n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge GCLK); #1; n++; end
    resp = s_axi_bresp;
    n_cmp++;
    if (!s_axi_bvalid) begin
      n_err++;
      $display("FAIL write_timeout: addr=%h bvalid=%b required 1", a, s_axi_bvalid);
    end
    @(posedge GCLK); #1;
    s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n; bit hs;
    s_axi_araddr = a; s_axi_arvalid = 1; n = 0; hs = 0;
    while (!hs && n < 20) begin
      hs = s_axi_arready;
      @(posedge GCLK); #1;
      n++;
    end
    s_axi_arvalid = 0;
    n_cmp++;
    if (!s_axi_rvalid) begin
      n_err++;
      $display("FAIL read_timeout: addr=%h rvalid=%b required 1", a, s_axi_rvalid);
    end
    d = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1;
    @(posedge GCLK); #1;
    s_axi_rready = 0;
  endtask

  task automatic wait_done();
    logic [31:0] d; logic [1:0] r; int n;
    d = 32'h1; n = 0;
    while (d[0] && n < 200) begin axi_read(5'h10, d, r); n++; end
    n_cmp++;
    if (d[0]) begin
      n_err++;
      $display("FAIL wait_done: busy=%b after %0d polls, required 0", d[0], n);
    end
  endtask

  task automatic check_regs(input string tag, input bit active);
    logic [4:0] addrs [5] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
    logic [31:0] d; logic [1:0] r; logic [33:0] e;
    for (int i = 0; i < 5; i++) begin
      axi_read(addrs[i], d, r);
      e = m_read(addrs[i], active);
      n_cmp++;
      if ({r, d} !== e) begin
        n_err++;
        $display("FAIL %s_read_%h: got resp=%b data=%h required resp=%b data=%h",
                 tag, addrs[i], r, d, e[33:32], e[31:0]);
      end
    end
    n_cmp++;
    if ({spi_mode_o, sck_speed_o, word_len_o, t_IFG_o, t_CS_SCK_o, t_SCK_CS_o, mosi_data_o, irq_o}
        !== {m_ctrl[1:0], m_ctrl[3:2], m_ctrl[5:4], m_timing[7:0], m_timing[15:8],
             m_timing[23:16], m_tx, m_done & m_ctrl[9]}) begin
      n_err++;
      $display("FAIL %s_outputs: got mode=%h spd=%h wl=%h ifg=%h cs=%h sc=%h tx=%h irq=%b required ctrl=%h timing=%h tx=%h irq=%b",
               tag, spi_mode_o, sck_speed_o, word_len_o, t_IFG_o, t_CS_SCK_o, t_SCK_CS_o,
               mosi_data_o, irq_o, m_ctrl, m_timing, m_tx, m_done & m_ctrl[9]);
    end
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (3) @(posedge GCLK);
    #1;
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, start_o, irq_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got %b required 0000000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, start_o, irq_o});
    end
    RST = 0;
    m_reset();
    check_regs("reset", 0);
  endtask

  task automatic test_regs_random();
    logic [4:0] a; logic [31:0] d, rd; logic [3:0] s; logic [1:0] r, e; logic [33:0] ex;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7) * 4);
      d = $urandom; s = 4'($urandom);
      if (a == 5'h00) d[8] = 1'b0;
      axi_write(a, d, s, r);
      e = m_write(a, d, s, 0);
      n_cmp++;
      if (r !== e) begin
        n_err++;
        $display("FAIL rand_bresp: addr=%h got %b required %b", a, r, e);
      end
      axi_read(a, rd, r);
      ex = m_read(a, 0);
      n_cmp++;
      if ({r, rd} !== ex) begin
        n_err++;
        $display("FAIL rand_read: addr=%h got resp=%b data=%h required resp=%b data=%h",
                 a, r, rd, ex[33:32], ex[31:0]);
      end
    end
    axi_read(5'h1C, rd, r);
    n_cmp++;
    if ({r, rd} !== {2'b10, 32'd0}) begin
      n_err++;
      $display("FAIL unmapped_read: got resp=%b data=%h required resp=10 data=0", r, rd);
    end
    check_regs("rand", 0);
  endtask

  task automatic test_transfer();
    logic [31:0] d; logic [1:0] r; int c0;
    m_skip = 0; m_len = 40; m_rxw = 32'h0000_000B;
    axi_write(5'h08, 32'hA5A5_1234, 4'hF, r);
    void'(m_write(5'h08, 32'hA5A5_1234, 4'hF, 0));
    c0 = start_cnt;
    axi_write(5'h00, 32'h0000_0330, 4'hF, r);
    void'(m_write(5'h00, 32'h0000_0330, 4'hF, 0));
    axi_read(5'h10, d, r);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL xfer_status_busy: got %h required 00000001", d);
    end
    wait_done();
    m_done = 1; m_rx = m_rxw;
    n_cmp++;
    if (start_cnt - c0 !== 1 || start_o !== 1'b0) begin
      n_err++;
      $display("FAIL xfer_start_pulses: got %0d pulses start_o=%b required 1 pulse start_o=0",
               start_cnt - c0, start_o);
    end
    check_regs("xfer_done", 0);
    axi_write(5'h10, 32'h2, 4'hF, r);
    void'(m_write(5'h10, 32'h2, 4'hF, 0));
    check_regs("xfer_w1c", 0);
  endtask

  task automatic test_retry();
    logic [1:0] r; logic [31:0] cfg; int c0, skip;
    skip = $urandom_range(1, 5);
    m_skip = skip; m_len = $urandom_range(5, 15); m_rxw = $urandom;
    cfg = ($urandom & 32'h0000_023F) | 32'h100;
    c0 = start_cnt; start_dbl = 0;
    axi_write(5'h00, cfg, 4'hF, r);
    void'(m_write(5'h00, cfg, 4'hF, 0));
    wait_done();
    m_done = 1; m_rx = m_rxw;
    n_cmp++;
    if (start_cnt - c0 !== skip + 1 || start_dbl !== 0) begin
      n_err++;
      $display("FAIL retry_pulses: got %0d pulses (%0d back-to-back) required %0d (0)",
               start_cnt - c0, start_dbl, skip + 1);
    end
    check_regs("retry", 0);
    axi_write(5'h10, 32'h6, 4'h1, r);
    void'(m_write(5'h10, 32'h6, 4'h1, 0));
  endtask

  task automatic test_busy_reject();
    logic [31:0] cfg, d; logic [1:0] r, e;
    m_skip = 0; m_len = 90; m_rxw = $urandom;
    cfg = ($urandom & 32'h0000_023F) | 32'h100;
    axi_write(5'h00, cfg, 4'hF, r);
    void'(m_write(5'h00, cfg, 4'hF, 0));
    d = $urandom;
    axi_write(5'h08, d, 4'hF, r);
    e = m_write(5'h08, d, 4'hF, 1);
    n_cmp++;
    if (r !== e) begin n_err++; $display("FAIL busy_tx_bresp: got %b required %b", r, e); end
    axi_write(5'h00, 32'h0000_0115, 4'hF, r);
    e = m_write(5'h00, 32'h0000_0115, 4'hF, 1);
    n_cmp++;
    if (r !== e) begin n_err++; $display("FAIL busy_start_bresp: got %b required %b", r, e); end
    check_regs("busy", 1);
    axi_write(5'h10, 32'h4, 4'hF, r);
    e = m_write(5'h10, 32'h4, 4'hF, 1);
    n_cmp++;
    if (r !== e) begin n_err++; $display("FAIL busy_status_bresp: got %b required %b", r, e); end
    axi_read(5'h10, d, r);
    n_cmp++;
    if (d !== m_read(5'h10, 1)) begin
      n_err++;
      $display("FAIL busy_status_w1c: got %h required %h", d, m_read(5'h10, 1));
    end
    wait_done();
    m_done = 1; m_rx = m_rxw;
    check_regs("busy_done", 0);
    axi_write(5'h10, 32'h6, 4'hF, r);
    void'(m_write(5'h10, 32'h6, 4'hF, 0));
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d, rd; logic [1:0] r;
    d = $urandom;
    s_axi_awaddr = 5'h08; s_axi_awvalid = 1;
    @(posedge GCLK); #1;
    s_axi_awaddr = 5'h04;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (s_axi_awready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL aw_wait_%0d: awready=%b bvalid=%b required 0 0", i, s_axi_awready, s_axi_bvalid);
      end
      @(posedge GCLK); #1;
    end
    s_axi_wdata = d; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    n_cmp++;
    if (s_axi_wready !== 1'b1) begin n_err++; $display("FAIL aw_wready: got %b required 1", s_axi_wready); end
    @(posedge GCLK); #1;
    s_axi_wvalid = 0;
    @(posedge GCLK); #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({s_axi_bvalid, s_axi_bresp, s_axi_awready} !== 4'b1000) begin
        n_err++;
        $display("FAIL b_hold_%0d: bvalid=%b bresp=%b awready=%b required 1 00 0",
                 i, s_axi_bvalid, s_axi_bresp, s_axi_awready);
      end
      @(posedge GCLK); #1;
    end
    s_axi_awvalid = 0; s_axi_bready = 1;
    @(posedge GCLK); #1;
    s_axi_bready = 0;
    n_cmp++;
    if (s_axi_bvalid !== 1'b0) begin n_err++; $display("FAIL b_release: bvalid=%b required 0", s_axi_bvalid); end
    void'(m_write(5'h08, d, 4'hF, 0));
    axi_read(5'h08, rd, r);
    n_cmp++;
    if ({r, rd} !== {2'b00, m_tx}) begin
      n_err++;
      $display("FAIL aw_first_data: got resp=%b data=%h required 00 %h", r, rd, m_tx);
    end
    check_regs("aw_first", 0);
  endtask

  task automatic test_reset_active();
    logic [31:0] d, cfg; logic [1:0] r;
    m_skip = 0; m_len = 100; m_rxw = $urandom;
    d = $urandom;
    axi_write(5'h04, d, 4'hF, r);
    void'(m_write(5'h04, d, 4'hF, 0));
    cfg = ($urandom & 32'h0000_023F) | 32'h300;
    axi_write(5'h00, cfg, 4'hF, r);
    void'(m_write(5'h00, cfg, 4'hF, 0));
    repeat (8) @(posedge GCLK);
    #1;
    RST = 1;
    @(posedge GCLK); #1;
    RST = 0;
    m_reset();
    n_cmp++;
    if ({start_o, irq_o, s_axi_bvalid, s_axi_rvalid} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_active_outputs: start=%b irq=%b bvalid=%b rvalid=%b required 0",
               start_o, irq_o, s_axi_bvalid, s_axi_rvalid);
    end
    check_regs("rst_active", 0);
  endtask

  initial begin
    RST = 1;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    m_reset();
    @(posedge GCLK); #1;
    test_reset();
    test_regs_random();
    test_transfer();
    test_retry();
    test_busy_reject();
    test_aw_before_w();
    test_reset_active();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
